lsu_dmem: RTL and testbench

Parametrised load/store unit with an embedded byte-addressed data memory for the RV32I core family. It accepts one RV32I load or store request at a time over a valid/ready handshake. Stores apply byte enables. Loads are aligned and sign- or zero-extended. Misaligned, illegal-funct3 and out-of-range accesses are flagged. Read latency is configurable, so the core can move from combinational data memory to a pipelined memory model.

---
 rtl/lsu_dmem_if.sv | 33 +++
 rtl/lsu_dmem.sv | 187 ++++++++++++++++++
 tb/tb_lsu_dmem.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_dmem_if.sv
// lsu_dmem_if: request/response bus between the core and the load/store unit.
//   Signal names follow the unit's point of view (_i driven by the core,
//   _o driven by the unit).
//   slave  : used by lsu_dmem
//   master : used by the core / testbench driver
//   req_*  : valid/ready request carrying we, funct3, byte address, store data
//   resp_* : valid/ready response carrying formatted load data and fault flag
interface lsu_dmem_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid_i;
  logic            req_ready_o;
  logic            req_we_i;
  logic [2:0]      req_funct3_i;
  logic [XLEN-1:0] req_addr_i;
  logic [XLEN-1:0] req_wdata_i;
  logic            resp_valid_o;
  logic            resp_ready_i;
  logic [XLEN-1:0] resp_rdata_o;
  logic            resp_err_o;

  modport slave (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
    input  resp_ready_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );

  modport master (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
    output resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );
endinterface

// File: rtl/lsu_dmem.sv
// lsu_dmem: RV32I load/store unit with an embedded byte-addressed data memory.
//   One request outstanding at a time. Stores write with byte enables at the
//   acceptance edge; loads read at acceptance and pass through RD_LATENCY-1
//   pipeline registers before sign/zero extension. Misaligned, illegal-funct3
//   and out-of-range accesses return err=1, rdata=0 and touch no memory.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : lsu_dmem_if.slave (request and response handshakes)
module lsu_dmem #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  lsu_dmem_if.slave  bus
);

  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
  localparam int unsigned NB     = XLEN / 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned PIPE_N = (RD_LATENCY > 1) ? RD_LATENCY - 1 : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         f3_q, f3_d;
  logic [1:0]         off_q, off_d;
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [XLEN-1:0]    rdata_q, rdata_d;

  logic [XLEN-1:0]    mem_q [MEM_WORDS];
  logic [XLEN-1:0]    pipe_q [PIPE_N];

  logic               acc_c;
  logic               acc_err_c;
  logic               mem_we_c;
  logic [IDX_W-1:0]   idx_c;
  logic [NB-1:0]      be_c;
  logic [XLEN-1:0]    wd_c;
  logic [XLEN-1:0]    rd_word_c;

  // Align the addressed byte/halfword to bit 0 and extend per funct3.
  function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] w,
                                               input logic [2:0]      f3,
                                               input logic [1:0]      off);
    logic [XLEN-1:0] s;
    s = w >> {off, 3'b000};
    case (f3)
      3'd0:    fmt_load = {{(XLEN-8){s[7]}},   s[7:0]};
      3'd1:    fmt_load = {{(XLEN-16){s[15]}}, s[15:0]};
      3'd4:    fmt_load = {{(XLEN-8){1'b0}},   s[7:0]};
      3'd5:    fmt_load = {{(XLEN-16){1'b0}},  s[15:0]};
      default: fmt_load = s;
    endcase
  endfunction

  assign acc_c     = bus.req_valid_i & ready_q;
  assign idx_c     = bus.req_addr_i[IDX_W+1:2];
  assign rd_word_c = mem_q[idx_c];

  // Fault detection on the incoming request.
  always_comb begin
    logic bad_f3;
    logic mis;
    logic oor;
    if (bus.req_we_i) bad_f3 = (bus.req_funct3_i >= 3'd3);
    else              bad_f3 = (bus.req_funct3_i == 3'd3) || (bus.req_funct3_i[2:1] == 2'b11);
    mis = ((bus.req_funct3_i[1:0] == 2'b01) && bus.req_addr_i[0]) ||
          ((bus.req_funct3_i[1:0] == 2'b10) && (bus.req_addr_i[1:0] != 2'b00));
    oor = |(bus.req_addr_i >> (IDX_W + 2));
    acc_err_c = bad_f3 | mis | oor;
  end

  // Store byte enables and lane-replicated write data.
  always_comb begin
    be_c = '0;
    wd_c = bus.req_wdata_i;
    case (bus.req_funct3_i[1:0])
      2'b00: begin
        be_c = NB'(1) << bus.req_addr_i[1:0];
        wd_c = {NB{bus.req_wdata_i[7:0]}};
      end
      2'b01: begin
        be_c = bus.req_addr_i[1] ? NB'(4'b1100) : NB'(4'b0011);
        wd_c = {(NB/2){bus.req_wdata_i[15:0]}};
      end
      default: be_c = '1;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    off_d    = off_q;
    valid_d  = valid_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    mem_we_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (acc_c) begin
          f3_d  = bus.req_funct3_i;
          off_d = bus.req_addr_i[1:0];
          err_d = acc_err_c;
          if (acc_err_c || bus.req_we_i) begin
            mem_we_c = bus.req_we_i & ~acc_err_c;
            state_d  = S_RESP;
            valid_d  = 1'b1;
            rdata_d  = '0;
          end else if (RD_LATENCY == 1) begin
            state_d = S_RESP;
            valid_d = 1'b1;
            rdata_d = fmt_load(rd_word_c, bus.req_funct3_i, bus.req_addr_i[1:0]);
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(RD_LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_RESP;
          cnt_d   = '0;
          valid_d = 1'b1;
          rdata_d = fmt_load(pipe_q[PIPE_N-1], f3_q, off_q);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (bus.resp_ready_i) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          err_d   = 1'b0;
          rdata_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  // Control and response registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Data memory and load pipeline; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < int'(NB); b++) begin
      if (mem_we_c && be_c[b]) mem_q[idx_c][8*b +: 8] <= wd_c[8*b +: 8];
    end
    if (acc_c) pipe_q[0] <= rd_word_c;
    for (int i = 1; i < int'(PIPE_N); i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign bus.req_ready_o  = ready_q;
  assign bus.resp_valid_o = valid_q;
  assign bus.resp_err_o   = err_q;
  assign bus.resp_rdata_o = rdata_q;

endmodule

// File: tb/tb_lsu_dmem.sv
// tb_lsu_dmem: directed self-checking bench for lsu_dmem (RD_LATENCY=3).
module tb_lsu_dmem;
  localparam int unsigned RDL = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lsu_dmem_if #(.XLEN(32)) bus ();

  lsu_dmem #(.XLEN(32), .MEM_WORDS(1024), .RD_LATENCY(RDL)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic accept(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'd0, 32'd1);
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = we;
    bus.req_funct3_i = f3;
    bus.req_addr_i   = addr;
    bus.req_wdata_i  = wd;
    @(posedge clk);
    #1;
    bus.req_valid_i  = 1'b0;
  endtask

  // Cycles after the acceptance edge until resp_valid_o is seen.
  task automatic wait_resp(output int lat);
    lat = 0;
    while (!bus.resp_valid_o && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (lat >= 50) chk("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic finish_resp(input string tag);
    @(negedge clk);
    bus.resp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready_i = 1'b0;
    chk({tag, "_rdy_after"}, 32'(bus.req_ready_o), 32'd1);
    chk({tag, "_vld_after"}, 32'(bus.resp_valid_o), 32'd0);
  endtask

  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    int exp_lat;
    exp_lat = (we || exp_err) ? 0 : int'(RDL) - 1;
    accept(we, f3, addr, wd);
    wait_resp(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rdata"}, bus.resp_rdata_o, exp_rd);
    chk({tag, "_err"}, 32'(bus.resp_err_o), 32'(exp_err));
    finish_resp(tag);
  endtask

  initial begin
    int lat;
    int vcount;
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'b0;
    bus.req_funct3_i = 3'd0;
    bus.req_addr_i   = '0;
    bus.req_wdata_i  = '0;
    bus.resp_ready_i = 1'b0;

    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", 32'(bus.req_ready_o), 32'd0);
    chk("rst_valid", 32'(bus.resp_valid_o), 32'd0);
    chk("rst_rdata", bus.resp_rdata_o, 32'd0);
    chk("rst_err",   32'(bus.resp_err_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_ready", 32'(bus.req_ready_o), 32'd1);

    // Byte lanes
    xact("sw10",   1'b1, 3'd2, 32'h10, 32'h0000_0000, 32'h0, 1'b0);
    xact("sb12",   1'b1, 3'd0, 32'h12, 32'hAAAA_AA80, 32'h0, 1'b0);
    xact("lw10",   1'b0, 3'd2, 32'h10, 32'h0, 32'h0080_0000, 1'b0);
    xact("lb12",   1'b0, 3'd0, 32'h12, 32'h0, 32'hFFFF_FF80, 1'b0);
    xact("lbu12",  1'b0, 3'd4, 32'h12, 32'h0, 32'h0000_0080, 1'b0);
    xact("sb13",   1'b1, 3'd0, 32'h13, 32'h0000_007F, 32'h0, 1'b0);
    xact("lb13",   1'b0, 3'd0, 32'h13, 32'h0, 32'h0000_007F, 1'b0);
    xact("lw10b",  1'b0, 3'd2, 32'h10, 32'h0, 32'h7F80_0000, 1'b0);

    // Halfwords
    xact("sw20",   1'b1, 3'd2, 32'h20, 32'h8001_7FFF, 32'h0, 1'b0);
    xact("lh22",   1'b0, 3'd1, 32'h22, 32'h0, 32'hFFFF_8001, 1'b0);
    xact("lhu22",  1'b0, 3'd5, 32'h22, 32'h0, 32'h0000_8001, 1'b0);
    xact("lh20",   1'b0, 3'd1, 32'h20, 32'h0, 32'h0000_7FFF, 1'b0);
    xact("lbu23",  1'b0, 3'd4, 32'h23, 32'h0, 32'h0000_0080, 1'b0);

    // Errors
    xact("lw21",   1'b0, 3'd2, 32'h21, 32'h0, 32'h0, 1'b1);
    xact("sh23",   1'b1, 3'd1, 32'h23, 32'h0000_FFFF, 32'h0, 1'b1);
    xact("lw20",   1'b0, 3'd2, 32'h20, 32'h0, 32'h8001_7FFF, 1'b0);
    xact("lf3_3",  1'b0, 3'd3, 32'h20, 32'h0, 32'h0, 1'b1);
    xact("lf3_6",  1'b0, 3'd6, 32'h20, 32'h0, 32'h0, 1'b1);
    xact("sf3_3",  1'b1, 3'd3, 32'h20, 32'h1111_1111, 32'h0, 1'b1);
    xact("lhu21",  1'b0, 3'd5, 32'h21, 32'h0, 32'h0, 1'b1);
    xact("lw1000", 1'b0, 3'd2, 32'h1000, 32'h0, 32'h0, 1'b1);
    xact("sw1010", 1'b1, 3'd2, 32'h1010, 32'hDEAD_BEEF, 32'h0, 1'b1);
    xact("lw10c",  1'b0, 3'd2, 32'h10, 32'h0, 32'h7F80_0000, 1'b0);
    xact("lw20b",  1'b0, 3'd2, 32'h20, 32'h0, 32'h8001_7FFF, 1'b0);

    // Backpressure on an LB response; a store offered meanwhile is ignored
    accept(1'b0, 3'd0, 32'h12, 32'h0);
    wait_resp(lat);
    chk("bp_lat", 32'(lat), 32'(RDL - 1));
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = 1'b1;
    bus.req_funct3_i = 3'd2;
    bus.req_addr_i   = 32'h10;
    bus.req_wdata_i  = 32'hDEAD_BEEF;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(bus.resp_valid_o), 32'd1);
      chk("bp_rdata", bus.resp_rdata_o, 32'hFFFF_FF80);
      chk("bp_err",   32'(bus.resp_err_o), 32'd0);
      chk("bp_ready", 32'(bus.req_ready_o), 32'd0);
    end
    bus.req_valid_i = 1'b0;
    finish_resp("bp");
    xact("lw10d",  1'b0, 3'd2, 32'h10, 32'h0, 32'h7F80_0000, 1'b0);

    // Reset during WAIT drops the load
    accept(1'b0, 3'd2, 32'h20, 32'h0);
    #3 rst = 1'b1;
    #1;
    chk("mid_ready", 32'(bus.req_ready_o), 32'd0);
    chk("mid_valid", 32'(bus.resp_valid_o), 32'd0);
    chk("mid_rdata", bus.resp_rdata_o, 32'd0);
    chk("mid_err",   32'(bus.resp_err_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rel_ready", 32'(bus.req_ready_o), 32'd1);
    vcount = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid_o) vcount++;
    end
    chk("mid_no_resp", 32'(vcount), 32'd0);

    // Reset while a store response is pending keeps the write
    accept(1'b1, 3'd2, 32'h30, 32'h1234_5678);
    #2 rst = 1'b1;
    #1;
    chk("st_rst_valid", 32'(bus.resp_valid_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    xact("lw30",   1'b0, 3'd2, 32'h30, 32'h0, 32'h1234_5678, 1'b0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
